pll_lock_reset_sequencer: RTL and testbench
===========================================

// Module: pll_lock_reset_sequencer
// PURPOSE
//  Sequences the audio-clock PLL (12.288 MHz AD1939 MCLK -> 98.304 MHz sys_clk): drives PLL reset,
//  waits for lock with timeout/retry, qualifies lock stability, then releases the downstream reset.
//  Runs on the free-running fabric clock, which is independent of the PLL. Sits beside the PLL in
//  the AD1939 subsystem. Downstream logic synchronizes sys_rst into the 98.304 MHz domain.
// PARAMETERS
//  RST_CYCLES     16    cycles pll_rst is held high per PLL reset attempt (>=2)
//  LOCK_TIMEOUT   4096  cycles allowed in WAIT_LOCK before a retry
//  STABLE_CYCLES  1024  consecutive synced-lock cycles required before RUN
//  MAX_RETRIES    3     timeouts tolerated before FAULT
//  CNT_W          16    width of the shared down/up timer (must hold max of above)
// PORTS
//  clk          in   1        fabric clock, free-running
//  rst          in   1        synchronous, active-high reset
//  restart_req  in   1        single-cycle software restart pulse
//  pll_locked   in   1        PLL locked, asynchronous to clk
//  pll_rst      out  1        to PLL rst
//  sys_rst      out  1        downstream reset, active-high
//  ready        out  1        high only in RUN
//  fault        out  1        high only in FAULT
//  retry_cnt    out  RW       timeouts in current attempt, RW=$clog2(MAX_RETRIES+1)
//  loss_cnt     out  16       lock-loss events in RUN (PLL_SEQ_LOSS_COUNT_EN only)
// BEHAVIOUR
//  - pll_locked passes a 2-FF synchronizer -> lock_s (2-cycle latency); only lock_s is used.
//  - Reset: state=PLL_RESET, timer=0, retry_cnt=0, loss_cnt=0, pll_rst=1, sys_rst=1, ready=0, fault=0.
//  - Outputs are registered Moore decodes of the state; they are valid in the first cycle of each state.
//  - PLL_RESET: pll_rst=1, sys_rst=1. Held exactly RST_CYCLES cycles, then -> WAIT_LOCK with timer cleared.
//  - WAIT_LOCK: pll_rst=0, sys_rst=1.
//    - lock_s=1 -> STABILIZE.
//    - Else, after LOCK_TIMEOUT cycles: if retry_cnt==MAX_RETRIES -> FAULT; else retry_cnt++ and -> PLL_RESET.
//  - STABILIZE: pll_rst=0, sys_rst=1.
//    - lock_s=0 -> WAIT_LOCK, timer restarts, retry_cnt unchanged.
//    - STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
//  - RUN: sys_rst=0, ready=1.
//    - lock_s=0 -> PLL_RESET; sys_rst=1 in that same next cycle; retry_cnt cleared.
//    - loss_cnt++ on that lock loss, saturating at 16'hFFFF.
//  - FAULT: pll_rst=1, sys_rst=1, fault=1. Exit only via restart_req or rst.
//  - restart_req in any state -> PLL_RESET next cycle, retry_cnt=0, timer=0; loss_cnt untouched.
//  - Priority: rst > restart_req > lock/timeout events. restart_req in PLL_RESET restarts its RST_CYCLES count.
//  - Timer is one CNT_W counter, cleared on every state change; no wrap (the terminal compare fires first).
//  - Glitch on lock_s shorter than one cycle is invisible; any single low cycle counts as a loss.
// CONFIGURATION
//  PLL_SEQ_LOSS_COUNT_EN defined:
//    - loss_cnt port and saturating counter present.
//    - Counter is cleared only by rst.
//  Undefined:
//    - No loss_cnt port and no counter logic.
//    - All other behaviour is identical.
// STRUCTURE
//  Package pll_seq_pkg: state enum {PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT}, 3-bit encoding,
//  plus localparam defaults for the timing values.
//  One sub-module: bit_sync2 (2-FF synchronizer, reset value 0). FSM, timer and counters stay in top.
// TESTING (RST_CYCLES=16, LOCK_TIMEOUT=64, STABLE_CYCLES=32, MAX_RETRIES=3)
//  1. Bring-up: release rst, raise pll_locked 10 cycles after pll_rst falls.
//     -> pll_rst high exactly 16 cycles; ready=1, sys_rst=0 at cycle 16+10+2+32 (+-1 FSM cycle).
//  2. No lock: hold pll_locked=0.
//     -> 4 PLL_RESET pulses of 16 cycles each; retry_cnt steps 0,1,2,3; fault=1 after the 4th timeout;
//        pll_rst stays 1.
//  3. Unstable lock: drop pll_locked for 1 cycle at cycle 20 of STABILIZE.
//     -> back to WAIT_LOCK, no pll_rst pulse, a full 32-cycle qualification is required again.
//  4. Loss in RUN: drop pll_locked.
//     -> sys_rst=1 and pll_rst=1 within 3 cycles (sync+FSM); retry_cnt=0; loss_cnt=1 with macro,
//        port absent without.
//  5. Restart from FAULT: pulse restart_req.
//     -> fault=0 next cycle; pll_rst pulse 16 cycles; normal bring-up follows.
//  6. Coincidence: restart_req in the same cycle as a timeout at retry_cnt=3.
//     -> PLL_RESET, not FAULT; retry_cnt=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// State encoding, default timing values and a saturating-increment helper
// shared by the PLL lock/reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 4096;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Metastability-settling pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a qualified lock, then releases sys_rst.
// Build option: define PLL_SEQ_LOSS_COUNT_EN to add the saturating loss_cnt port and counter.
module pll_lock_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int  RST_CYCLES    = DEF_RST_CYCLES,
    parameter int  LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int  STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int  MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int  CNT_W         = DEF_CNT_W,
    localparam int RW            = $clog2(MAX_RETRIES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart_req,
    input  logic          pll_locked,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fault,
`ifdef PLL_SEQ_LOSS_COUNT_EN
    output logic [15:0]   loss_cnt,
`endif
    output logic [RW-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [RW-1:0]    RETRY_ONE   = RW'(1);

    pll_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_s;

    bit_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next state, timer and retry count; restart_req overrides every in-state event.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_ONE;
        retry_d = retry_q;
        if (restart_req) begin
            state_d = PLL_RESET;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        state_d = PLL_RESET;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        timer_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = FAULT;
                        end else begin
                            state_d = PLL_RESET;
                            retry_d = retry_q + RETRY_ONE;
                        end
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else begin
                        state_d = STABILIZE;
                    end
                end
                RUN: begin
                    timer_d = '0;
                    if (!lock_s) begin
                        state_d = PLL_RESET;
                        retry_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                    timer_d = '0;
                end
                default: begin
                    state_d = PLL_RESET;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the upcoming state so they are valid in its first cycle.
    always_comb begin
        pll_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            PLL_RESET: pll_rst_d = 1'b1;
            WAIT_LOCK: pll_rst_d = 1'b0;
            STABILIZE: pll_rst_d = 1'b0;
            RUN: begin
                pll_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            FAULT:     fault_d   = 1'b1;
            default:   pll_rst_d = 1'b1;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PLL_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [15:0] loss_q, loss_d;

    // A lock loss ending RUN is counted unless a restart request wins that cycle.
    always_comb begin
        if (!restart_req && (state_q == RUN) && !lock_s) begin
            loss_d = sat_inc16(loss_q);
        end else begin
            loss_d = loss_q;
        end
    end

    // Loss counter survives restart requests; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 16'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Self-checking bench for pll_lock_reset_sequencer: directed vectors plus randomized
// lock/restart traffic against a cycle-count reference model.
module tb_pll_lock_reset_sequencer;

    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 32;
    localparam int MAX_RETRIES   = 3;

    localparam int M_RST   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart_req = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [15:0] loss_cnt;
    int          m_losses;
`endif

    always #5 clk = ~clk;

    pll_lock_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .restart_req (restart_req),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
`ifdef PLL_SEQ_LOSS_COUNT_EN
        .loss_cnt    (loss_cnt),
`endif
        .retry_cnt   (retry_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_phase, m_age, m_retries;
    bit lock_hist[$];

    typedef struct {
        int       cycle;
        bit       restart;
        bit       locked;
        bit [5:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
        end
    endtask

    task automatic model_enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    function automatic int model_out();
        bit pr, sr, rd, ft;
        pr = (m_phase == M_RST) || (m_phase == M_FAULT);
        sr = (m_phase != M_RUN);
        rd = (m_phase == M_RUN);
        ft = (m_phase == M_FAULT);
        return int'({pr, sr, rd, ft, 2'(m_retries)});
    endfunction

    // One clock edge of the reference model; lock seen by the sequencer lags the pin by two samples.
    task automatic model_step(input bit rq);
        bit seen;
        seen = (lock_hist.size() >= 2) ? lock_hist[1] : 1'b0;
        m_age++;
        if (rq) begin
            m_retries = 0;
            model_enter(M_RST);
        end else begin
            case (m_phase)
                M_RST:  if (m_age == RST_CYCLES) model_enter(M_WAIT);
                M_WAIT: begin
                    if (seen) model_enter(M_STAB);
                    else if (m_age == LOCK_TIMEOUT) begin
                        if (m_retries == MAX_RETRIES) model_enter(M_FAULT);
                        else begin
                            m_retries++;
                            model_enter(M_RST);
                        end
                    end
                end
                M_STAB: begin
                    if (!seen) model_enter(M_WAIT);
                    else if (m_age == STABLE_CYCLES) model_enter(M_RUN);
                end
                M_RUN: begin
                    if (!seen) begin
`ifdef PLL_SEQ_LOSS_COUNT_EN
                        if (m_losses < 65535) m_losses++;
`endif
                        m_retries = 0;
                        model_enter(M_RST);
                    end
                end
                default: ;
            endcase
        end
        lock_hist.push_front(pll_locked);
        if (lock_hist.size() > 2) void'(lock_hist.pop_back());
    endtask

    task automatic tick(input bit rq, input bit lk);
        restart_req = rq;
        pll_locked  = lk;
        @(posedge clk);
        model_step(rq);
        cyc++;
        #1;
        chk("model_outputs", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), model_out());
`ifdef PLL_SEQ_LOSS_COUNT_EN
        chk("model_loss_cnt", int'(loss_cnt), m_losses);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        restart_req = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        m_retries = 0;
        lock_hist.delete();
        model_enter(M_RST);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        m_losses = 0;
        chk("reset_loss_cnt", int'(loss_cnt), 0);
`endif
        chk("reset_outputs", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), 6'b110000);
    endtask

    initial begin
        bit saw_rst;
        bit lvl;
        int len;
        int waited;

        // {cycle, restart, locked, {pll_rst, sys_rst, ready, fault, retry_cnt}}
        vecs.push_back('{15,  1'b0, 1'b0, 6'b110000});
        vecs.push_back('{16,  1'b0, 1'b0, 6'b010000});
        vecs.push_back('{79,  1'b0, 1'b0, 6'b010000});
        vecs.push_back('{80,  1'b0, 1'b0, 6'b110001});
        vecs.push_back('{95,  1'b0, 1'b0, 6'b110001});
        vecs.push_back('{96,  1'b0, 1'b0, 6'b010001});
        vecs.push_back('{160, 1'b0, 1'b0, 6'b110010});
        vecs.push_back('{240, 1'b0, 1'b0, 6'b110011});
        vecs.push_back('{319, 1'b0, 1'b0, 6'b010011});
        vecs.push_back('{320, 1'b0, 1'b0, 6'b110111});
        vecs.push_back('{330, 1'b0, 1'b0, 6'b110111});
        vecs.push_back('{331, 1'b1, 1'b0, 6'b110000});
        vecs.push_back('{346, 1'b0, 1'b0, 6'b110000});
        vecs.push_back('{347, 1'b0, 1'b0, 6'b010000});

        // Bring-up, then loss of lock while running.
        do_reset();
        repeat (15) tick(1'b0, 1'b0);
        chk("bringup_rst_hold", pll_rst, 1);
        tick(1'b0, 1'b0);
        chk("bringup_rst_release", pll_rst, 0);
        repeat (10) tick(1'b0, 1'b0);
        repeat (34) tick(1'b0, 1'b1);
        chk("bringup_not_ready", int'({ready, sys_rst}), 2'b01);
        tick(1'b0, 1'b1);
        chk("bringup_ready", int'({ready, sys_rst}), 2'b10);
        repeat (2) tick(1'b0, 1'b0);
        chk("loss_still_run", ready, 1);
        tick(1'b0, 1'b0);
        chk("loss_reset", int'({pll_rst, sys_rst, ready, retry_cnt}), 5'b11000);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        chk("loss_count", int'(loss_cnt), 1);
`endif

        // One-cycle lock drop during qualification.
        do_reset();
        repeat (16) tick(1'b0, 1'b0);
        repeat (23) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        saw_rst = 1'b0;
        repeat (34) begin
            tick(1'b0, 1'b1);
            if (pll_rst) saw_rst = 1'b1;
        end
        chk("unstable_no_pll_rst", saw_rst, 0);
        chk("unstable_requalify", ready, 0);
        tick(1'b0, 1'b1);
        chk("unstable_ready", ready, 1);

        // No lock: retry ladder into FAULT, then restart from FAULT (vector table).
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cycle) begin
                tick((cyc == vecs[i].cycle - 1) ? vecs[i].restart : 1'b0, vecs[i].locked);
            end
            chk($sformatf("vec%0d", i), int'({pll_rst, sys_rst, ready, fault, retry_cnt}),
                int'(vecs[i].exp));
        end
        waited = 0;
        while (!ready && waited < 80) begin
            tick(1'b0, 1'b1);
            waited++;
        end
        chk("restart_bringup_ready", ready, 1);

        // Restart coincident with the final timeout.
        do_reset();
        repeat (319) tick(1'b0, 1'b0);
        chk("coinc_pre", int'({pll_rst, fault, retry_cnt}), 4'b0011);
        tick(1'b1, 1'b0);
        chk("coinc_restart", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), 6'b110000);

        // Randomized lock/restart traffic against the model.
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            if (seg % 40 == 39) do_reset();
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? int'($urandom_range(1, 140)) : int'($urandom_range(1, 90));
            for (int k = 0; k < len; k++) begin
                tick($urandom_range(0, 299) == 0, lvl);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
